// File: rtl/vx_ibuffer_if.sv
// vx_ibuffer_if: decoded-instruction bus with valid/ready handshake.
interface vx_ibuffer_if #(
    parameter int NW_BITS     = 2,
    parameter int NUM_THREADS = 4,
    parameter int EX_BITS     = 3,
    parameter int OP_BITS     = 4,
    parameter int MOD_BITS    = 3,
    parameter int NR_BITS     = 6,
    parameter int NUM_REGS    = 64
);
    logic                   valid;
    logic                   ready;
    logic [NW_BITS-1:0]     wid;
    logic [NUM_THREADS-1:0] tmask;
    logic [31:0]            PC;
    logic [EX_BITS-1:0]     ex_type;
    logic [OP_BITS-1:0]     op_type;
    logic [MOD_BITS-1:0]    op_mod;
    logic                   wb;
    logic [NR_BITS-1:0]     rd;
    logic [NR_BITS-1:0]     rs1;
    logic [NR_BITS-1:0]     rs2;
    logic [NR_BITS-1:0]     rs3;
    logic [31:0]            imm;
    logic                   use_PC;
    logic                   use_imm;
    logic [NUM_REGS-1:0]    used_regs;

    modport master (
        output valid, wid, tmask, PC, ex_type, op_type, op_mod, wb, rd, rs1, rs2, rs3,
               imm, use_PC, use_imm, used_regs,
        input  ready
    );
    modport slave (
        input  valid, wid, tmask, PC, ex_type, op_type, op_mod, wb, rd, rs1, rs2, rs3,
               imm, use_PC, use_imm, used_regs,
        output ready
    );
endinterface

// File: rtl/vx_ibuffer.sv
// vx_ibuffer: per-warp instruction FIFOs with round-robin dequeue into a registered
// output slot; an instruction arriving while every FIFO is empty bypasses straight to the output.
module vx_ibuffer #(
    parameter int NUM_WARPS   = 4,
    parameter int IBUF_SIZE   = 4,
    parameter int NUM_THREADS = 4,
    parameter int EX_BITS     = 3,
    parameter int OP_BITS     = 4,
    parameter int MOD_BITS    = 3,
    parameter int NR_BITS     = 6,
    parameter int NUM_REGS    = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    vx_ibuffer_if.slave          decode_if,
    vx_ibuffer_if.master         ibuf_deq_if,
    output logic [NUM_WARPS-1:0] warp_pending
);
    localparam int NWB = $clog2(NUM_WARPS);
    localparam int PW  = $clog2(IBUF_SIZE);
    localparam int CW  = $clog2(IBUF_SIZE + 1);
    localparam int DW  = NUM_THREADS + 32 + EX_BITS + OP_BITS + MOD_BITS + 1 + 4 * NR_BITS
                       + 32 + 2 + NUM_REGS;

    logic [DW-1:0]                fifo_q [NUM_WARPS][IBUF_SIZE];
    logic [DW-1:0]                fifo_d [NUM_WARPS][IBUF_SIZE];
    logic [NUM_WARPS-1:0][PW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
    logic [NUM_WARPS-1:0][CW-1:0] count_q, count_d;
    logic [NWB-1:0]               rr_ptr_q, rr_ptr_d;
    logic                         out_valid_q, out_valid_d;
    logic [NWB-1:0]               out_wid_q, out_wid_d;
    logic [DW-1:0]                out_data_q, out_data_d;
    logic [NUM_WARPS-1:0]         full, empty;
    logic [NWB-1:0]               grant, idx;
    logic                         grant_valid, enq_fire, out_free, pop, enq_fifo;
    logic [DW-1:0]                din;

    assign din = {decode_if.tmask, decode_if.PC, decode_if.ex_type, decode_if.op_type,
                  decode_if.op_mod, decode_if.wb, decode_if.rd, decode_if.rs1, decode_if.rs2,
                  decode_if.rs3, decode_if.imm, decode_if.use_PC, decode_if.use_imm,
                  decode_if.used_regs};

    // A full warp refuses input even if it is being popped this cycle.
    assign decode_if.ready = !full[decode_if.wid] && !reset;
    assign enq_fire        = decode_if.valid && decode_if.ready;
    assign out_free        = !out_valid_q || ibuf_deq_if.ready;
    assign pop             = out_free && grant_valid;
    assign enq_fifo        = enq_fire && !(out_free && !grant_valid);
    assign warp_pending    = ~empty;

    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            full[w]  = count_q[w] == CW'(IBUF_SIZE);
            empty[w] = count_q[w] == '0;
        end
        // Descending scan so the warp closest after rr_ptr wins.
        for (int i = NUM_WARPS - 1; i >= 0; i--) begin
            idx = rr_ptr_q + NWB'(i + 1);
            if (!empty[idx]) begin
                grant       = idx;
                grant_valid = 1'b1;
            end
        end
    end

    always_comb begin
        fifo_d      = fifo_q;
        rptr_d      = rptr_q;
        wptr_d      = wptr_q;
        rr_ptr_d    = rr_ptr_q;
        out_valid_d = out_valid_q;
        out_wid_d   = out_wid_q;
        out_data_d  = out_data_q;
        if (enq_fifo) begin
            fifo_d[decode_if.wid][wptr_q[decode_if.wid]] = din;
            wptr_d[decode_if.wid] = wptr_q[decode_if.wid] + PW'(1);
        end
        if (pop) begin
            rptr_d[grant] = rptr_q[grant] + PW'(1);
            rr_ptr_d      = grant;
        end
        for (int w = 0; w < NUM_WARPS; w++)
            count_d[w] = count_q[w] + CW'(enq_fifo && decode_if.wid == NWB'(w))
                                    - CW'(pop && grant == NWB'(w));
        if (out_free) begin
            out_valid_d = grant_valid || enq_fire;
            out_wid_d   = grant_valid ? grant : enq_fire ? decode_if.wid : '0;
            out_data_d  = grant_valid ? fifo_q[grant][rptr_q[grant]] : enq_fire ? din : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rptr_q      <= '0;
            wptr_q      <= '0;
            count_q     <= '0;
            rr_ptr_q    <= NWB'(NUM_WARPS - 1);
            out_valid_q <= 1'b0;
            out_wid_q   <= '0;
            out_data_q  <= '0;
        end else begin
            rptr_q      <= rptr_d;
            wptr_q      <= wptr_d;
            count_q     <= count_d;
            rr_ptr_q    <= rr_ptr_d;
            out_valid_q <= out_valid_d;
            out_wid_q   <= out_wid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Storage is gated by the counts, so it needs no reset.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    assign ibuf_deq_if.valid = out_valid_q;
    assign ibuf_deq_if.wid   = out_wid_q;
    assign {ibuf_deq_if.tmask, ibuf_deq_if.PC, ibuf_deq_if.ex_type, ibuf_deq_if.op_type,
            ibuf_deq_if.op_mod, ibuf_deq_if.wb, ibuf_deq_if.rd, ibuf_deq_if.rs1, ibuf_deq_if.rs2,
            ibuf_deq_if.rs3, ibuf_deq_if.imm, ibuf_deq_if.use_PC, ibuf_deq_if.use_imm,
            ibuf_deq_if.used_regs} = out_data_q;
endmodule

// File: tb/tb_vx_ibuffer.sv
// tb_vx_ibuffer: directed scenario tests for vx_ibuffer with hand-computed expectations.
module tb_vx_ibuffer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] warp_pending;
    int         errors = 0;
    int         checks = 0;

    vx_ibuffer_if dec();
    vx_ibuffer_if deq();

    vx_ibuffer dut (
        .clk         (clk),
        .reset       (reset),
        .decode_if   (dec),
        .ibuf_deq_if (deq),
        .warp_pending(warp_pending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] w, input logic [31:0] pc);
        dec.valid     = v;
        dec.wid       = w;
        dec.PC        = pc;
        dec.imm       = ~pc;
        dec.tmask     = pc[5:2];
        dec.rd        = pc[7:2];
        dec.rs1       = 6'd1;
        dec.rs2       = 6'd2;
        dec.rs3       = 6'd3;
        dec.ex_type   = 3'd1;
        dec.op_type   = 4'd5;
        dec.op_mod    = 3'd2;
        dec.wb        = 1'b1;
        dec.use_PC    = pc[2];
        dec.use_imm   = pc[3];
        dec.used_regs = {32'h0, pc};
    endtask

    task automatic enq(input logic [1:0] w, input logic [31:0] pc);
        drive(1'b1, w, pc);
        step();
        drive(1'b0, 2'd0, 32'h0);
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, 32'h0);
        deq.ready = 1'b0;
        #2 reset = 1'b1;
        step();
        step();
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset();
        drive(1'b1, 2'd0, 32'h1234);
        deq.ready = 1'b1;
        #3 reset = 1'b1;
        #1;
        checks++; if (dec.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", dec.ready); end
        checks++; if (deq.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", deq.valid); end
        checks++; if (warp_pending !== 4'b0) begin errors++; $display("FAIL reset_pending got=%b exp=0000", warp_pending); end
        checks++; if (deq.PC !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h exp=00000000", deq.PC); end
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 2'd0, 32'h0);
        step();
    endtask

    task automatic test_bypass();
        do_reset();
        deq.ready = 1'b1;
        drive(1'b1, 2'd1, 32'h80000000);
        #1;
        checks++; if (dec.ready !== 1'b1) begin errors++; $display("FAIL bypass_ready got=%b exp=1", dec.ready); end
        step();
        drive(1'b0, 2'd0, 32'h0);
        checks++; if (deq.valid !== 1'b1) begin errors++; $display("FAIL bypass_valid got=%b exp=1", deq.valid); end
        checks++; if (deq.wid !== 2'd1) begin errors++; $display("FAIL bypass_wid got=%0d exp=1", deq.wid); end
        checks++; if (deq.PC !== 32'h80000000) begin errors++; $display("FAIL bypass_pc got=%h exp=80000000", deq.PC); end
        checks++; if (warp_pending !== 4'b0) begin errors++; $display("FAIL bypass_pending got=%b exp=0000", warp_pending); end
        step();
        checks++; if (deq.valid !== 1'b0) begin errors++; $display("FAIL bypass_clear got=%b exp=0", deq.valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 5; i++) enq(2'd2, 32'h200 + 32'(4 * i));
        drive(1'b1, 2'd2, 32'h999);
        #1;
        checks++; if (dec.ready !== 1'b0) begin errors++; $display("FAIL full_ready_w2 got=%b exp=0", dec.ready); end
        drive(1'b1, 2'd1, 32'h999);
        #1;
        checks++; if (dec.ready !== 1'b1) begin errors++; $display("FAIL full_ready_w1 got=%b exp=1", dec.ready); end
        drive(1'b0, 2'd0, 32'h0);
        checks++; if (deq.PC !== 32'h200) begin errors++; $display("FAIL full_hold_pc got=%h exp=00000200", deq.PC); end
        checks++; if (warp_pending !== 4'b0100) begin errors++; $display("FAIL full_pending got=%b exp=0100", warp_pending); end
        deq.ready = 1'b1;
        for (int i = 1; i < 5; i++) begin
            step();
            checks++; if (deq.PC !== 32'h200 + 32'(4 * i)) begin errors++; $display("FAIL full_drain_pc%0d got=%h exp=%h", i, deq.PC, 32'h200 + 32'(4 * i)); end
            checks++; if (deq.wid !== 2'd2) begin errors++; $display("FAIL full_drain_wid%0d got=%0d exp=2", i, deq.wid); end
        end
        step();
        checks++; if (deq.valid !== 1'b0) begin errors++; $display("FAIL full_drained_valid got=%b exp=0", deq.valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0]  wl [6] = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        logic [31:0] pl [6] = '{32'h0, 32'h100, 32'h300, 32'h4, 32'h104, 32'h304};
        do_reset();
        enq(2'd2, 32'hD00);
        for (int i = 0; i < 6; i++) enq(wl[i], pl[i]);
        checks++; if (warp_pending !== 4'b1011) begin errors++; $display("FAIL rr_pending got=%b exp=1011", warp_pending); end
        deq.ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (deq.wid !== wl[i]) begin errors++; $display("FAIL rr_wid%0d got=%0d exp=%0d", i, deq.wid, wl[i]); end
            checks++; if (deq.PC !== pl[i]) begin errors++; $display("FAIL rr_pc%0d got=%h exp=%h", i, deq.PC, pl[i]); end
        end
        checks++; if (warp_pending !== 4'b0) begin errors++; $display("FAIL rr_pending_end got=%b exp=0000", warp_pending); end
    endtask

    task automatic test_push_pop();
        logic [31:0] pl [4] = '{32'hA4, 32'hA8, 32'hAC, 32'hB0};
        do_reset();
        enq(2'd2, 32'hD00);
        enq(2'd0, 32'hA0);
        enq(2'd0, 32'hA4);
        enq(2'd0, 32'hA8);
        deq.ready = 1'b1;
        drive(1'b1, 2'd0, 32'hAC);
        step();
        drive(1'b0, 2'd0, 32'h0);
        deq.ready = 1'b0;
        checks++; if (deq.PC !== 32'hA0) begin errors++; $display("FAIL pp_pc got=%h exp=000000a0", deq.PC); end
        checks++; if (warp_pending !== 4'b0001) begin errors++; $display("FAIL pp_pending got=%b exp=0001", warp_pending); end
        enq(2'd0, 32'hB0);
        drive(1'b1, 2'd0, 32'h999);
        #1;
        checks++; if (dec.ready !== 1'b0) begin errors++; $display("FAIL pp_full_ready got=%b exp=0", dec.ready); end
        drive(1'b0, 2'd0, 32'h0);
        deq.ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if (deq.PC !== pl[i]) begin errors++; $display("FAIL pp_drain_pc%0d got=%h exp=%h", i, deq.PC, pl[i]); end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        enq(2'd3, 32'h3000);
        enq(2'd1, 32'h1000);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (deq.PC !== 32'h3000 || deq.imm !== ~32'h3000) begin errors++; $display("FAIL bp_payload%0d got=%h/%h exp=00003000/ffffcfff", i, deq.PC, deq.imm); end
            checks++; if (deq.wid !== 2'd3 || deq.valid !== 1'b1) begin errors++; $display("FAIL bp_wid%0d got=%0d/%b exp=3/1", i, deq.wid, deq.valid); end
            checks++; if (warp_pending !== 4'b0010) begin errors++; $display("FAIL bp_pending%0d got=%b exp=0010", i, warp_pending); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        enq(2'd0, 32'h50);
        enq(2'd0, 32'h54);
        enq(2'd0, 32'h58);
        enq(2'd1, 32'h150);
        enq(2'd1, 32'h154);
        enq(2'd2, 32'h250);
        enq(2'd2, 32'h254);
        checks++; if (warp_pending !== 4'b0111) begin errors++; $display("FAIL rm_pending_pre got=%b exp=0111", warp_pending); end
        #3 reset = 1'b1;
        #1;
        checks++; if (deq.valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%b exp=0", deq.valid); end
        checks++; if (warp_pending !== 4'b0) begin errors++; $display("FAIL rm_pending got=%b exp=0000", warp_pending); end
        @(negedge clk);
        reset = 1'b0;
        deq.ready = 1'b1;
        drive(1'b1, 2'd3, 32'h77);
        step();
        drive(1'b0, 2'd0, 32'h0);
        checks++; if (deq.valid !== 1'b1 || deq.wid !== 2'd3) begin errors++; $display("FAIL rm_bypass got=%b/%0d exp=1/3", deq.valid, deq.wid); end
        checks++; if (deq.PC !== 32'h77) begin errors++; $display("FAIL rm_bypass_pc got=%h exp=00000077", deq.PC); end
        checks++; if (warp_pending !== 4'b0) begin errors++; $display("FAIL rm_bypass_pending got=%b exp=0000", warp_pending); end
    endtask

    initial begin
        drive(1'b0, 2'd0, 32'h0);
        deq.ready = 1'b0;
        step();
        test_reset();
        test_bypass();
        test_full();
        test_round_robin();
        test_push_pop();
        test_back_pressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
